// File: rtl/inferencia_min_max_if.sv
// rtl/inferencia_min_max_if.sv - sequencer/defuzzifier-side bus of the min-max inference stage
interface inferencia_min_max_if #(parameter int W = 8);
  logic           EN_REGRAS;
  logic [5:0]     regra;
  logic [3*W-1:0] mu_e;
  logic [3*W-1:0] mu_de;
  logic [5*W-1:0] forca;
  logic           valido;
  logic           erro;
  logic [3:0]     n_regras;

  modport master (
    output EN_REGRAS, regra, mu_e, mu_de,
    input  forca, valido, erro, n_regras
  );

  modport slave (
    input  EN_REGRAS, regra, mu_e, mu_de,
    output forca, valido, erro, n_regras
  );
endinterface

// File: rtl/inferencia_min_max.sv
// rtl/inferencia_min_max.sv - min-max fuzzy rule inference; rule counter enabled by FUZZY_CONTADOR_REGRAS_EN
module inferencia_min_max #(parameter int W = 8) (
  input logic                 clk,
  input logic                 rst,
  inferencia_min_max_if.slave bus
);
  typedef enum logic {IDLE, ACUM} state_t;

  state_t            state_q;
  logic [2:0][W-1:0] snap_e_q, snap_de_q;
  logic [4:0][W-1:0] acc_q, acc_d;
  logic [5*W-1:0]    forca_q;
  logic              valido_q, erro_q;

  logic [1:0]   idx_i, idx_j;
  logic [2:0]   k;
  logic [W-1:0] deg_e, deg_de, m;
  logic         rule_ok, do_start, do_end, do_rule;

  assign idx_i   = bus.regra[3:2];
  assign idx_j   = bus.regra[1:0];
  assign rule_ok = (idx_i != 2'd3) && (idx_j != 2'd3);
  assign k       = {1'b0, idx_i} + {1'b0, idx_j};

  // END outranks Start, which outranks a rule code
  assign do_end   = bus.EN_REGRAS && bus.regra[5] && (state_q == ACUM);
  assign do_start = bus.EN_REGRAS && !bus.regra[5] && bus.regra[4];
  assign do_rule  = bus.EN_REGRAS && !bus.regra[5] && !bus.regra[4] && (state_q == ACUM);

  always_comb begin
    case (idx_i)
      2'd0:    deg_e = snap_e_q[0];
      2'd1:    deg_e = snap_e_q[1];
      2'd2:    deg_e = snap_e_q[2];
      default: deg_e = '0;
    endcase
    case (idx_j)
      2'd0:    deg_de = snap_de_q[0];
      2'd1:    deg_de = snap_de_q[1];
      2'd2:    deg_de = snap_de_q[2];
      default: deg_de = '0;
    endcase
    m     = (deg_e < deg_de) ? deg_e : deg_de;
    acc_d = acc_q;
    for (int n = 0; n < 5; n++) begin
      if (k == 3'(n) && m > acc_q[n]) acc_d[n] = m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      snap_e_q  <= '0;
      snap_de_q <= '0;
      acc_q     <= '0;
      forca_q   <= '0;
      valido_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      valido_q <= 1'b0;
      if (do_end) begin
        forca_q  <= acc_q;
        valido_q <= 1'b1;
        state_q  <= IDLE;
      end else if (do_start) begin
        snap_e_q  <= bus.mu_e;
        snap_de_q <= bus.mu_de;
        acc_q     <= '0;
        erro_q    <= 1'b0;
        state_q   <= ACUM;
      end else if (do_rule) begin
        if (rule_ok) acc_q  <= acc_d;
        else         erro_q <= 1'b1;
      end
    end
  end

  assign bus.forca  = forca_q;
  assign bus.valido = valido_q;
  assign bus.erro   = erro_q;

`ifdef FUZZY_CONTADOR_REGRAS_EN
  logic [3:0] cnt_q, n_regras_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      n_regras_q <= '0;
    end else if (do_end) begin
      n_regras_q <= cnt_q;
    end else if (do_start) begin
      cnt_q <= '0;
    end else if (do_rule && rule_ok && cnt_q != 4'd15) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign bus.n_regras = n_regras_q;
`else
  assign bus.n_regras = '0;
`endif
endmodule

// File: tb/tb_inferencia_min_max.sv
// tb/tb_inferencia_min_max.sv - directed and randomized checks against a burst-level reference model
module tb_inferencia_min_max;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inferencia_min_max_if #(.W(W)) bus();
  inferencia_min_max #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  int e_v[3];
  int de_v[3];

  bit m_busy;
  int m_se[3], m_sde[3], m_acc[5], m_forca[5];
  int m_cnt, m_n;
  bit m_err, m_val;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_cnt = 0; m_n = 0; m_err = 0; m_val = 0;
    for (int x = 0; x < 3; x++) begin m_se[x] = 0; m_sde[x] = 0; end
    for (int x = 0; x < 5; x++) begin m_acc[x] = 0; m_forca[x] = 0; end
  endtask

  task automatic model_edge(input bit r, input bit en, input logic [5:0] code);
    int i, j;
    if (r) begin
      model_clear();
      return;
    end
    m_val = 0;
    if (!en) return;
    i = int'(code[3:2]);
    j = int'(code[1:0]);
    if (code[5]) begin
      if (m_busy) begin
        m_forca = m_acc;
        m_n     = m_cnt;
        m_val   = 1;
        m_busy  = 0;
      end
    end else if (code[4]) begin
      m_se   = e_v;
      m_sde  = de_v;
      for (int x = 0; x < 5; x++) m_acc[x] = 0;
      m_cnt  = 0;
      m_err  = 0;
      m_busy = 1;
    end else if (m_busy) begin
      if (i < 3 && j < 3) begin
        m_acc[i+j] = imax(m_acc[i+j], imin(m_se[i], m_sde[j]));
        m_cnt      = imin(m_cnt + 1, 15);
      end else begin
        m_err = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [5*W-1:0] ef;
    int en_exp;
    for (int x = 0; x < 5; x++) ef[x*W +: W] = W'(m_forca[x]);
`ifdef FUZZY_CONTADOR_REGRAS_EN
    en_exp = m_n;
`else
    en_exp = 0;
`endif
    chk("forca", 64'(bus.forca), 64'(ef));
    chk("valido", 64'(bus.valido), 64'(m_val));
    chk("erro", 64'(bus.erro), 64'(m_err));
    chk("n_regras", 64'(bus.n_regras), 64'(en_exp));
  endtask

  task automatic step(input bit r, input bit en, input logic [5:0] code);
    @(negedge clk);
    rst           = r;
    bus.EN_REGRAS = en;
    bus.regra     = code;
    bus.mu_e      = {W'(e_v[2]), W'(e_v[1]), W'(e_v[0])};
    bus.mu_de     = {W'(de_v[2]), W'(de_v[1]), W'(de_v[0])};
    @(posedge clk);
    model_edge(r, en, code);
    #1;
    check_all();
  endtask

  task automatic set_mu(input int e0, e1, e2, d0, d1, d2);
    e_v[0] = e0; e_v[1] = e1; e_v[2] = e2;
    de_v[0] = d0; de_v[1] = d1; de_v[2] = d2;
  endtask

  localparam logic [5:0] C_END   = 6'b100000;
  localparam logic [5:0] C_START = 6'b010000;

  initial begin
    logic [5:0] code;
    int nr;
    rst = 1'b1;
    bus.EN_REGRAS = 1'b0;
    bus.regra = '0;
    bus.mu_e = '0;
    bus.mu_de = '0;
    set_mu(0, 0, 0, 0, 0, 0);
    model_clear();

    // END straight after reset is ignored, Start alone does not publish
    step(1, 0, 6'b0);
    step(1, 1, C_END);
    chk("reset_forca", 64'(bus.forca), 64'h0);
    step(0, 1, C_END);
    chk("end_idle_valido", 64'(bus.valido), 64'h0);
    step(0, 1, C_START);
    step(0, 1, 6'b000000);
    chk("start_valido", 64'(bus.valido), 64'h0);

    set_mu(200, 50, 0, 100, 180, 0);
    step(0, 1, C_START);
    step(0, 1, 6'b000000);
    step(0, 1, 6'b000001);
    step(0, 1, 6'b000100);
    step(0, 1, 6'b000101);
    step(0, 1, C_END);
    chk("plan_forca", 64'(bus.forca), 64'h00_00_32_B4_64);
    chk("plan_valido", 64'(bus.valido), 64'h1);
    step(0, 1, 6'b000000);
    chk("plan_valido_drop", 64'(bus.valido), 64'h0);

    // Same burst with disabled gaps carrying a live-looking code
    step(0, 1, C_START);
    for (int r = 0; r < 4; r++) begin
      step(0, 1, 6'(r == 2 ? 4 : (r == 3 ? 5 : r)));
      for (int g = 0; g < 3; g++) step(0, 0, 6'b000101);
    end
    step(0, 1, C_END);
    chk("gap_forca", 64'(bus.forca), 64'h00_00_32_B4_64);

    // Illegal index sets the sticky flag without touching accumulators
    step(0, 1, C_START);
    step(0, 1, 6'b000000);
    step(0, 1, 6'b000011);
    chk("erro_set", 64'(bus.erro), 64'h1);
    step(0, 1, C_END);
    chk("erro_forca", 64'(bus.forca), 64'h00_00_00_00_64);
    chk("erro_hold", 64'(bus.erro), 64'h1);
    step(0, 1, C_START);
    chk("erro_clear", 64'(bus.erro), 64'h0);

    // Reset mid-burst, then a fresh burst on set pair (2,2)
    step(0, 1, 6'b000000);
    step(0, 1, 6'b000001);
    step(1, 1, 6'b000001);
    chk("rst_forca", 64'(bus.forca), 64'h0);
    set_mu(0, 0, 255, 0, 0, 30);
    step(0, 1, C_START);
    step(0, 1, 6'b001010);
    step(0, 1, C_END);
    chk("rst_burst_forca", 64'(bus.forca), 64'h1E_00_00_00_00);
    step(0, 1, 6'b000000);

    // Only the snapshot taken at Start matters
    set_mu(200, 0, 0, 100, 0, 0);
    step(0, 1, C_START);
    set_mu(0, 0, 0, 100, 0, 0);
    step(0, 1, 6'b000000);
    step(0, 1, C_END);
    chk("snap_forca", 64'(bus.forca), 64'h00_00_00_00_64);

    for (int b = 0; b < 60; b++) begin
      for (int x = 0; x < 3; x++) begin
        e_v[x]  = int'($urandom_range(0, 255));
        de_v[x] = int'($urandom_range(0, 255));
      end
      step(0, 1, C_START);
      nr = int'($urandom_range(0, 20));
      for (int r = 0; r < nr; r++) begin
        code = {2'b00, 4'($urandom_range(0, 15))};
        if ($urandom_range(0, 40) == 0) code = C_START;
        step(($urandom_range(0, 150) == 0), ($urandom_range(0, 3) != 0), code);
        if ($urandom_range(0, 3) == 0) e_v[$urandom_range(0, 2)] = int'($urandom_range(0, 255));
      end
      step(0, ($urandom_range(0, 7) != 0), C_END);
      step(0, ($urandom_range(0, 1) != 0), 6'($urandom_range(0, 63)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inferencia_min_max.md
# inferencia_min_max

Min-max inference stage placed directly downstream of the rule-sequencing state machine in the fuzzy processor. It consumes the 6-bit rule code the sequencer emits each enabled cycle. For each fired rule it takes the AND (min) of the selected error and delta-error membership degrees, and OR-aggregates (max) the result into one of five output-set strengths. On the sequencer's END code it publishes the aggregated strengths to the defuzzifier with a one-cycle valid pulse.

## Interface
- W, 8, bit width of every membership degree and strength.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- EN_REGRAS  in  1  step enable shared with the sequencer; block only acts in cycles where it is 1.
- regra  in  6  rule code from sequencer: bit5 = END, bit4 = Start, [3:2] = error index i, [1:0] = delta-error index j.
- mu_e  in  3*W  error degrees; set i at [i*W +: W].
- mu_de  in  3*W  delta-error degrees; set j at [j*W +: W].
- forca  out  5*W  aggregated strengths; output set k at [k*W +: W].
- valido  out  1  one-cycle pulse: forca updated.
- erro  out  1  sticky: illegal rule index seen in current burst.
- n_regras  out  4  rules applied in last burst (see Configuration).

## Operation
- States: IDLE, ACUM.
- Code decode, priority order: bit5=1 → END; else bit4=1 → Start; else rule (i,j).
- All decode and state changes happen only when EN_REGRAS=1. When EN_REGRAS=0, all registers hold and valido=0.
- Start, in any state:
  - snapshot mu_e and mu_de into internal registers;
  - clear all five accumulators, erro and rule counter to 0;
  - go to ACUM.
  - Repeated Start codes (sequencer idling in Start) re-snapshot and re-clear each time.
- Rule in ACUM:
  - i≤2 and j≤2: m = min(snap_e[i], snap_de[j]); k = i+j; acc[k] = max(acc[k], m); counter +1, saturating at 15.
  - i=3 or j=3: no accumulator change; erro ← 1.
- Rule in IDLE: ignored.
- END in ACUM:
  - forca ← acc;
  - n_regras ← counter;
  - valido=1 for the next cycle;
  - go to IDLE.
  - erro keeps its value until the next Start.
- END in IDLE: ignored, no valido. This covers the END the sequencer emits right after reset.
- Duplicate rule in a burst: no effect beyond the first, because max is idempotent. The counter still increments.
- Arithmetic: unsigned W-bit compares only; no widening, no overflow possible.

## Timing
- Reset values: forca=0, valido=0, erro=0, n_regras=0, state IDLE, accumulators 0, snapshots 0.
- Rule code sampled at edge n → accumulator updated at edge n.
- END sampled at edge n → forca, n_regras, valido=1 visible after edge n. valido returns to 0 after edge n+1 unless another END is accepted.
- A rule immediately followed by END is included in forca (zero-bubble).
- forca holds its value between bursts until the next END in ACUM.
- Reset asserted mid-burst: everything returns to reset values at that edge. No valido is produced for the aborted burst.
- mu_e and mu_de may change freely after the Start cycle; only the snapshot is used.

## Configuration
- FUZZY_CONTADOR_REGRAS_EN defined: rule counter is implemented, n_regras reports rules applied (saturating 15) per burst, latched on END.
- Not defined: counter logic is omitted and n_regras is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then END, then Start, both with EN_REGRAS=1 → valido never asserted, forca=0.
- Burst with W=8, mu_e0=200, mu_e1=50, mu_de0=100, mu_de1=180. Codes Start, 000000, 000001, 000100, 000101, END → forca sets 0..4 = 100, 180, 50, 0, 0. valido pulses exactly once, one cycle after END. n_regras=4 (0 without macro).
- Same burst with EN_REGRAS=0 for 3 cycles between rules, with regra driven to 000101 while disabled → result identical to the previous scenario.
- Burst containing 000011 → erro=1 through END and the result, no accumulator change. erro clears on the next Start.
- rst asserted after two rules of a burst, then a full new burst with mu_e2=255, mu_de2=30 and code 001010 → forca set 4 = 30, all others 0, single valido.
- Change mu_e to 0 in the cycle after Start, then apply rule 000000 and END → forca set 0 = min of the snapshot values, not 0.
